// File: rtl/traffic_light_seq.sv
// traffic_light_seq
//   Timed traffic-light sequencer: RED -> GREEN -> YELLOW -> RED, each phase a
//   fixed number of prescaler ticks. A latched pedestrian request may end
//   GREEN early once GREEN_MIN_TICKS have elapsed. Drives the 2-bit colour code
//   of the downstream LED colour/PWM stage.
//
//   Optional feature macro: TL_MAINT_EN (adds the maint input and a
//   maintenance state that flashes YELLOW/BLUE).
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   maint        in   maintenance mode request (TL_MAINT_EN builds only)
//   ped_req      in   pedestrian request level, synchronous and debounced
//   color  [1:0] out  0=RED 1=YELLOW 2=GREEN 3=BLUE, registered
//   remaining[7:0] out ticks left in the current phase, registered
//   ped_pending  out  latched pedestrian request, registered
//   tick         out  one-cycle pulse, registered copy of the internal tick
module traffic_light_seq #(
  parameter int unsigned TICK_CYCLES     = 100000000,
  parameter int unsigned RED_TICKS       = 5,
  parameter int unsigned GREEN_TICKS     = 5,
  parameter int unsigned YELLOW_TICKS    = 2,
  parameter int unsigned GREEN_MIN_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst,
`ifdef TL_MAINT_EN
  input  logic       maint,
`endif
  input  logic       ped_req,
  output logic [1:0] color,
  output logic [7:0] remaining,
  output logic       ped_pending,
  output logic       tick
);

  localparam int unsigned   PW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_CYCLES - 1);
  localparam logic [7:0]    RED_LEN   = 8'(RED_TICKS);
  localparam logic [7:0]    GREEN_LEN = 8'(GREEN_TICKS);
  localparam logic [7:0]    YEL_LEN   = 8'(YELLOW_TICKS);
  // GREEN may be cut short once remaining has fallen to this value or below,
  // i.e. once GREEN_MIN_TICKS ticks complete with this tick.
  localparam logic [7:0]    EARLY_MAX = 8'(GREEN_TICKS - GREEN_MIN_TICKS + 1);

  localparam logic [1:0] C_RED    = 2'd0;
  localparam logic [1:0] C_YELLOW = 2'd1;
  localparam logic [1:0] C_GREEN  = 2'd2;
`ifdef TL_MAINT_EN
  localparam logic [1:0] C_BLUE   = 2'd3;
`endif

  typedef enum logic [1:0] {
    S_RED,
    S_GREEN,
    S_YELLOW
`ifdef TL_MAINT_EN
    , S_MAINT
`endif
  } state_t;

  state_t        state, state_nx;
  logic [1:0]    color_nx;
  logic [7:0]    remaining_nx;
  logic          ped_nx;
  logic [PW-1:0] pre_cnt;
  logic          tick_i;

  // Free-running prescaler, independent of the phase state.
  assign tick_i = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      pre_cnt <= tick_i ? '0 : pre_cnt + 1'b1;
      tick    <= tick_i;
    end
  end

  // State register; colour, remaining and ped_pending are registered here too
  // so colour carries no extra latency relative to state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RED;
      color       <= C_RED;
      remaining   <= RED_LEN;
      ped_pending <= 1'b0;
    end else begin
      state       <= state_nx;
      color       <= color_nx;
      remaining   <= remaining_nx;
      ped_pending <= ped_nx;
    end
  end

  // Next-state, phase counter and pedestrian latch.
  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    ped_nx       = ped_pending;

    case (state)
      S_RED: begin
        if (tick_i) begin
          if (remaining == 8'd1) begin
            state_nx     = S_GREEN;
            remaining_nx = GREEN_LEN;
          end else begin
            remaining_nx = remaining - 8'd1;
          end
        end
      end
      S_GREEN: begin
        if (tick_i) begin
          if (remaining == 8'd1 || (ped_pending && remaining <= EARLY_MAX)) begin
            state_nx     = S_YELLOW;
            remaining_nx = YEL_LEN;
          end else begin
            remaining_nx = remaining - 8'd1;
          end
        end
      end
      S_YELLOW: begin
        if (tick_i) begin
          if (remaining == 8'd1) begin
            state_nx     = S_RED;
            remaining_nx = RED_LEN;
          end else begin
            remaining_nx = remaining - 8'd1;
          end
        end
      end
`ifdef TL_MAINT_EN
      S_MAINT: begin
        state_nx     = S_RED;
        remaining_nx = RED_LEN;
      end
`endif
      default: begin
        state_nx     = S_RED;
        remaining_nx = RED_LEN;
      end
    endcase

    if (ped_req && (state == S_GREEN || state == S_YELLOW))
      ped_nx = 1'b1;
    // Clear on RED entry takes priority over a same-edge set.
    if (state_nx == S_RED && state != S_RED)
      ped_nx = 1'b0;

`ifdef TL_MAINT_EN
    if (maint) begin
      state_nx     = S_MAINT;
      remaining_nx = '0;
      ped_nx       = 1'b0;
    end
`endif
  end

  // Colour follows the next state; in maintenance it enters as YELLOW and then
  // alternates with BLUE on every tick.
  always_comb begin
    color_nx = C_RED;
    case (state_nx)
      S_RED:    color_nx = C_RED;
      S_GREEN:  color_nx = C_GREEN;
      S_YELLOW: color_nx = C_YELLOW;
`ifdef TL_MAINT_EN
      S_MAINT: begin
        if (state != S_MAINT)
          color_nx = C_YELLOW;
        else if (tick_i)
          color_nx = (color == C_YELLOW) ? C_BLUE : C_YELLOW;
        else
          color_nx = color;
      end
`endif
      default:  color_nx = C_RED;
    endcase
  end

endmodule
